cpu_run_controller: RTL

Host-side sequencer for the pipelined RISC-V core in the TinyTapeout top level. It accepts a byte-serial command stream from the dedicated inputs and loads instruction memory with 32-bit words. It holds the core in reset while loading, then releases it to free-run or to single-step a fixed number of cycles. It also counts executed cycles and stops on a halt indication from the core.

---
 rtl/cpu_run_if.sv | 27 ++
 rtl/cpu_run_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_if.sv
// cpu_run_if: host-facing byte command stream plus instruction-memory write port
// for cpu_run_controller.
//   cmd_valid / cmd_data / cmd_ready : byte-serial command handshake
//   imem_we / imem_waddr / imem_wdata : instruction-memory write port
// Modports:
//   master : host side, drives commands and observes the memory write port
//   slave  : controller side, accepts commands and drives the memory write port
interface cpu_run_if #(
    parameter int IMEM_AW = 6
);
    logic               cmd_valid;
    logic [7:0]         cmd_data;
    logic               cmd_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: host-side sequencer for the pipelined RISC-V core.
// Decodes a byte-serial command stream, loads instruction memory with
// little-endian 32-bit words while holding the core in reset, then releases
// the core to free-run (RUN) or to advance a fixed number of cycles (STEP).
// Counts enabled cycles and stops on a halt indication from the core.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : cpu_run_if.slave (command handshake + imem write port)
//   halt_req   : core retired ebreak
//   cpu_rst    : active-high reset to the core pipeline
//   cpu_en     : pipeline advance enable
//   busy       : controller not idle
//   timeout    : sticky RUN-limit flag
//   cycle_cnt  : saturating count of cpu_en-high cycles since last clear
//
// Optional feature macro: RUN_LIMIT_EN
//   Defined   : RUN is forced back to IDLE once cycle_cnt reaches RUN_LIMIT,
//               and timeout is set.
//   Undefined : no limit logic; timeout is tied to 0.
module cpu_run_controller #(
    parameter int IMEM_AW = 6,
    parameter int CNT_W   = 16
`ifdef RUN_LIMIT_EN
    ,
    parameter logic [CNT_W-1:0] RUN_LIMIT = 16'hFFFF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    cpu_run_if.slave         bus,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LD_CNT,
        LD_DATA,
        LD_WR,
        RUN,
        STEP_ARG,
        STEP
    } state_t;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_RUN   = 8'h02;
    localparam logic [7:0] OP_STEP  = 8'h03;
    localparam logic [7:0] OP_STOP  = 8'h04;
    localparam logic [7:0] OP_RESET = 8'h05;

    state_t             state;
    logic [8:0]         word_cnt;   // 1..256 words remaining
    logic [1:0]         byte_idx;
    logic [7:0]         step_cnt;
    logic [IMEM_AW-1:0] waddr_q;
    logic [31:0]        wdata_q;
    logic               we_q;
    logic               accept;
    logic               limit_hit;
    logic [CNT_W-1:0]   cnt_next;

    assign bus.cmd_ready  = (state != LD_WR) && (state != STEP);
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign busy           = (state != IDLE);

    // Saturating increment on every enabled cycle.
    assign cnt_next = (cpu_en && (cycle_cnt != {CNT_W{1'b1}})) ? cycle_cnt + 1'b1 : cycle_cnt;

`ifdef RUN_LIMIT_EN
    logic timeout_q;

    // Stop on the edge where the count lands on the limit, so cpu_en is high
    // for exactly RUN_LIMIT cycles of a RUN started from a cleared counter.
    assign limit_hit = (state == RUN) && cpu_en && (cnt_next >= RUN_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (limit_hit) begin
            timeout_q <= 1'b1;
        end else if ((state == IDLE) && accept &&
                     ((bus.cmd_data == OP_LOAD) || (bus.cmd_data == OP_RESET))) begin
            timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_rst   <= 1'b1;
            cpu_en    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cycle_cnt <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            step_cnt  <= '0;
        end else begin
            cycle_cnt <= cnt_next;
            we_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.cmd_data)
                            OP_LOAD: begin
                                cpu_rst   <= 1'b1;
                                cpu_en    <= 1'b0;
                                waddr_q   <= '0;
                                cycle_cnt <= '0;
                                state     <= LD_CNT;
                            end
                            OP_RUN: begin
                                cpu_rst <= 1'b0;
                                cpu_en  <= 1'b1;
                                state   <= RUN;
                            end
                            OP_STEP: state <= STEP_ARG;
                            OP_RESET: begin
                                cpu_rst   <= 1'b1;
                                cpu_en    <= 1'b0;
                                cycle_cnt <= '0;
                            end
                            default: ;  // STOP and unknown opcodes are no-ops here
                        endcase
                    end
                end
                LD_CNT: begin
                    if (accept) begin
                        word_cnt <= (bus.cmd_data == 8'd0) ? 9'd256 : {1'b0, bus.cmd_data};
                        byte_idx <= 2'd0;
                        state    <= LD_DATA;
                    end
                end
                LD_DATA: begin
                    if (accept) begin
                        wdata_q[{byte_idx, 3'b000} +: 8] <= bus.cmd_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            we_q  <= 1'b1;
                            state <= LD_WR;
                        end
                    end
                end
                LD_WR: begin
                    // Address/data held stable during the write; advance afterwards.
                    waddr_q  <= waddr_q + 1'b1;
                    word_cnt <= word_cnt - 9'd1;
                    state    <= (word_cnt == 9'd1) ? IDLE : LD_DATA;
                end
                RUN: begin
                    if (halt_req || limit_hit || (accept && (bus.cmd_data == OP_STOP))) begin
                        cpu_en <= 1'b0;
                        state  <= IDLE;
                    end
                end
                STEP_ARG: begin
                    if (accept) begin
                        if (bus.cmd_data != 8'd0) begin
                            step_cnt <= bus.cmd_data;
                            cpu_rst  <= 1'b0;
                            cpu_en   <= 1'b1;
                            state    <= STEP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                STEP: begin
                    if (halt_req || (step_cnt == 8'd1)) begin
                        cpu_en <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        step_cnt <= step_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
